// File: rtl/nios_cpu_div_pkg.sv
// Shared types and constants for the NIOS iterative divider cell.
// State encodings are plain 2-bit constants so older netlists and probes keep matching them.
package nios_cpu_div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

    typedef logic [1:0] div_state_t;

    localparam div_state_t ST_IDLE = 2'd0;
    localparam div_state_t ST_PREP = 2'd1;
    localparam div_state_t ST_ITER = 2'd2;
    localparam div_state_t ST_FIX  = 2'd3;

    // Width of the iteration counter, which counts WIDTH-1 down to 0.
    function automatic int div_cnt_width(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/nios_cpu_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, then subtract the divisor if it fits.
module nios_cpu_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem,
    input  logic             dvd_msb,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH:0]   rem_next,
    output logic             q_bit
);

    logic [WIDTH+1:0] shifted;

    always_comb begin
        shifted  = {rem, dvd_msb};
        q_bit    = (shifted >= {2'b00, dvs});
        rem_next = q_bit ? (WIDTH+1)'(shifted - {2'b00, dvs}) : shifted[WIDTH:0];
    end

endmodule

// File: rtl/nios_cpu_div_cell.sv
// Iterative radix-2 signed/unsigned divider: IDLE -> PREP -> ITER x WIDTH -> FIX.
// Optional build macro NIOS_DIV_EARLY_OUT_EN skips ITER when |dividend| < |divisor|.
module nios_cpu_div_cell
    import nios_cpu_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_start,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] div_src1,
    input  logic [WIDTH-1:0] div_src2,
    output logic             div_busy,
    output logic             div_done,
    output logic [WIDTH-1:0] div_quotient,
    output logic [WIDTH-1:0] div_remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = div_cnt_width(WIDTH);

    div_state_t       state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] src1_reg, src2_reg;
    logic             signed_reg;
    logic [WIDTH-1:0] dvd_reg, dvs_reg;
    logic [WIDTH:0]   rem_reg;
    logic             neg_q_reg, neg_r_reg, bypass_reg, dz_pend_reg;
    logic [WIDTH-1:0] quotient_reg, remainder_reg;
    logic             dz_reg, busy_reg, done_reg;

    logic [WIDTH-1:0] mag1, mag2;
    logic             sign1, sign2;
    logic [WIDTH:0]   rem_next;
    logic             q_bit;

    always_comb begin
        sign1 = signed_reg & src1_reg[WIDTH-1];
        sign2 = signed_reg & src2_reg[WIDTH-1];
        mag1  = sign1 ? -src1_reg : src1_reg;
        mag2  = sign2 ? -src2_reg : src2_reg;
    end

    nios_cpu_div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_reg),
        .dvd_msb  (dvd_reg[WIDTH-1]),
        .dvs      (dvs_reg),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            src1_reg      <= '0;
            src2_reg      <= '0;
            signed_reg    <= 1'b0;
            dvd_reg       <= '0;
            dvs_reg       <= '0;
            rem_reg       <= '0;
            neg_q_reg     <= 1'b0;
            neg_r_reg     <= 1'b0;
            bypass_reg    <= 1'b0;
            dz_pend_reg   <= 1'b0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            dz_reg        <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (div_start) begin
                        src1_reg   <= div_src1;
                        src2_reg   <= div_src2;
                        signed_reg <= div_signed;
                        busy_reg   <= 1'b1;
                        state_reg  <= ST_PREP;
                    end
                end
                ST_PREP: begin
                    dvs_reg     <= mag2;
                    neg_q_reg   <= sign1 ^ sign2;
                    neg_r_reg   <= sign1;
                    dz_pend_reg <= (src2_reg == '0);
                    // Shortcut paths park final results in dvd/rem and let FIX pass them through.
                    if (src2_reg == '0) begin
                        dvd_reg    <= '1;
                        rem_reg    <= {1'b0, src1_reg};
                        bypass_reg <= 1'b1;
                        state_reg  <= ST_FIX;
`ifdef NIOS_DIV_EARLY_OUT_EN
                    end else if (mag1 < mag2) begin
                        dvd_reg    <= '0;
                        rem_reg    <= {1'b0, src1_reg};
                        bypass_reg <= 1'b1;
                        state_reg  <= ST_FIX;
`endif
                    end else begin
                        dvd_reg    <= mag1;
                        rem_reg    <= '0;
                        bypass_reg <= 1'b0;
                        cnt_reg    <= CNT_W'(WIDTH - 1);
                        state_reg  <= ST_ITER;
                    end
                end
                ST_ITER: begin
                    // Dividend shifts out at the top while quotient bits fill in at the bottom.
                    dvd_reg <= {dvd_reg[WIDTH-2:0], q_bit};
                    rem_reg <= rem_next;
                    if (cnt_reg == '0) begin
                        state_reg <= ST_FIX;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                ST_FIX: begin
                    quotient_reg  <= (!bypass_reg && neg_q_reg) ? -dvd_reg : dvd_reg;
                    remainder_reg <= (!bypass_reg && neg_r_reg) ? -rem_reg[WIDTH-1:0]
                                                                : rem_reg[WIDTH-1:0];
                    dz_reg        <= dz_pend_reg;
                    done_reg      <= 1'b1;
                    busy_reg      <= 1'b0;
                    state_reg     <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign div_busy      = busy_reg;
    assign div_done      = done_reg;
    assign div_quotient  = quotient_reg;
    assign div_remainder = remainder_reg;
    assign div_by_zero   = dz_reg;

endmodule

// File: tb/tb_nios_cpu_div_cell.sv
// Self-checking bench for nios_cpu_div_cell: arithmetic reference model checked every cycle,
// directed literal cases, then a randomized start/operand stream.
module tb_nios_cpu_div_cell;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         div_start = 1'b0;
    logic         div_signed = 1'b0;
    logic [W-1:0] div_src1 = '0;
    logic [W-1:0] div_src2 = '0;
    logic         div_busy, div_done, div_by_zero;
    logic [W-1:0] div_quotient, div_remainder;

    int n_cmp = 0;
    int n_err = 0;

    nios_cpu_div_cell #(.WIDTH(W)) dut (
        .clk           (clk),
        .reset         (reset),
        .div_start     (div_start),
        .div_signed    (div_signed),
        .div_src1      (div_src1),
        .div_src2      (div_src2),
        .div_busy      (div_busy),
        .div_done      (div_done),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder),
        .div_by_zero   (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Plain-arithmetic reference for results and latency (edges from start to done).
    function automatic void ref_div(input bit sg, input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] q, output logic [W-1:0] r,
                                    output bit dz, output int lat);
        longint ma, mb;
        dz  = (b == 0);
        lat = W + 2;
        if (b == 0) begin
            q   = '1;
            r   = a;
            lat = 2;
        end else if (sg) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = a;
                r = '0;
            end else begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end
        end else begin
            q = a / b;
            r = a % b;
        end
        ma = sg ? longint'($signed(a)) : longint'(a);
        mb = sg ? longint'($signed(b)) : longint'(b);
        if (ma < 0) ma = -ma;
        if (mb < 0) mb = -mb;
`ifdef NIOS_DIV_EARLY_OUT_EN
        if (b != 0 && ma < mb) lat = 2;
`else
        if (ma < 0) lat = 0;
`endif
    endfunction

    // Transaction-level model: accepted op becomes pending for 'lat' edges, then results appear.
    bit           m_pending = 0, m_busy = 0, m_done = 0, m_dz = 0, p_dz = 0, m_was_idle = 0;
    logic [W-1:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
    int           m_left = 0, p_lat = 0;
    bit           p_sg = 0;
    logic [W-1:0] p_a = '0, p_b = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pending = 0; m_busy = 0; m_done = 0;
            m_q = '0; m_r = '0; m_dz = 0; m_left = 0;
        end else begin
            m_was_idle = !m_pending;
            m_done = 0;
            if (m_pending) begin
                m_left--;
                if (m_left == 0) begin
                    m_pending = 0; m_busy = 0; m_done = 1;
                    m_q = p_q; m_r = p_r; m_dz = p_dz;
                    $display("op sg=%0d a=%h b=%h -> q=%h r=%h dz=%0d lat=%0d",
                             p_sg, p_a, p_b, p_q, p_r, p_dz, p_lat);
                end
            end
            if (m_was_idle && div_start) begin
                p_sg = div_signed; p_a = div_src1; p_b = div_src2;
                ref_div(p_sg, p_a, p_b, p_q, p_r, p_dz, p_lat);
                m_left = p_lat; m_pending = 1; m_busy = 1;
            end
        end
    end

    always @(negedge clk) begin
        chk("done",      W'(div_done),    W'(m_done));
        chk("busy",      W'(div_busy),    W'(m_busy));
        chk("quotient",  div_quotient,    m_q);
        chk("remainder", div_remainder,   m_r);
        chk("by_zero",   W'(div_by_zero), W'(m_dz));
    end

    // Directed op with literal expectations; entered and left at #1 after a rising edge.
    task automatic run_op(input string tag, input bit sg, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er, input bit edz, input int elat);
        int n;
        bit got;
        div_signed = sg; div_src1 = a; div_src2 = b; div_start = 1'b1;
        @(posedge clk); #1;
        div_start = 1'b0;
        n = 0; got = 0;
        while (!got && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (div_done) got = 1;
        end
        chk({tag, " latency"}, W'(n), W'(elat));
        chk({tag, " q"}, div_quotient, eq);
        chk({tag, " r"}, div_remainder, er);
        chk({tag, " dz"}, W'(div_by_zero), W'(edz));
    endtask

    initial begin
        int early_lat;
        int mode;
`ifdef NIOS_DIV_EARLY_OUT_EN
        early_lat = 2;
`else
        early_lat = W + 2;
`endif
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("reset q", div_quotient, 32'h0);
        chk("reset busy", W'(div_busy), 32'h0);

        run_op("u100/7",  0, 32'd100,        32'd7,        32'd14,        32'd2,         0, 34);
        run_op("s-7/2",   1, 32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 0, 34);
        run_op("u-7/2",   0, 32'hFFFF_FFF9,  32'd2,        32'h7FFF_FFFC, 32'd1,         0, 34);
        run_op("u5/0",    0, 32'd5,          32'd0,        32'hFFFF_FFFF, 32'd5,         1, 2);
        run_op("s5/0",    1, 32'd5,          32'd0,        32'hFFFF_FFFF, 32'd5,         1, 2);
        run_op("sMIN/-1", 1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 32'd0,        0, 34);
        run_op("u3/10",   0, 32'd3,          32'd10,       32'd0,         32'd3,         0, early_lat);

        // Abort by reset mid-op; a start pulse while busy must be ignored.
        div_signed = 0; div_src1 = 32'd100; div_src2 = 32'd7; div_start = 1'b1;
        @(posedge clk); #1 div_start = 1'b0;
        repeat (9) @(posedge clk);
        #1 div_src1 = 32'd9; div_src2 = 32'd3; div_start = 1'b1;
        @(posedge clk); #1 div_start = 1'b0;
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        chk("abort q", div_quotient, 32'h0);
        chk("abort r", div_remainder, 32'h0);
        chk("abort busy", W'(div_busy), 32'h0);
        run_op("u9/3", 0, 32'd9, 32'd3, 32'd3, 32'd0, 0, 34);

        // Random start stream: back-to-back and ignored starts arise naturally.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            div_start  = ($urandom_range(0, 3) == 0);
            div_signed = $urandom_range(0, 1);
            mode = $urandom_range(0, 5);
            case (mode)
                0: begin div_src1 = $urandom; div_src2 = $urandom_range(0, 15); end
                1: begin div_src1 = $urandom_range(0, 50); div_src2 = $urandom_range(0, 50); end
                2: begin div_src1 = $urandom; div_src2 = 32'd0; end
                3: begin div_src1 = 32'h8000_0000; div_src2 = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : $urandom; end
                default: begin div_src1 = $urandom; div_src2 = $urandom; end
            endcase
        end
        #1 div_start = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
